// File: rtl/timer_scheduler.sv
// Round-robin owner of one shared prescaled 8-bit down-count timer.
// Each granted requester gets a delay of N ticks and a one-cycle done pulse when it expires.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | timer free; arbitrate pending requests from the pointer
// RUN     | owner's prescaler and countdown running; watches for abort
// DONE    | one-cycle done pulse to the owner; grant and busy still high
module timer_scheduler #(
    parameter int NUM_REQ    = 4,
    parameter int PRESCALE_W = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [8*NUM_REQ-1:0]      req_delay,
    input  logic [PRESCALE_W-1:0]     prescale,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        done,
    output logic                      busy,
    output logic [7:0]                count_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]            state_q,     state_d;
    logic [NUM_REQ-1:0]    grant_q,     grant_d;
    logic [NUM_REQ-1:0]    done_q,      done_d;
    logic                  busy_q,      busy_d;
    logic [7:0]            count_q,     count_d;
    logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
    logic [PRESCALE_W-1:0] presc_lat_q, presc_lat_d;
    logic [IDX_W-1:0]      ptr_q,       ptr_d;
    logic [IDX_W-1:0]      owner_q,     owner_d;

    logic                  win_found;
    logic [IDX_W-1:0]      win_idx;
    logic [7:0]            win_delay;
    logic [NUM_REQ-1:0]    win_onehot;
    logic                  tick;
    logic [IDX_W-1:0]      ptr_after_owner;

    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) begin
            s = s - NUM_REQ;
        end
        return IDX_W'(s);
    endfunction

    // First pending request at or after the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!win_found && req[wrap_add(ptr_q, k)]) begin
                win_found = 1'b1;
                win_idx   = wrap_add(ptr_q, k);
            end
        end
    end

    assign win_delay       = req_delay[8*win_idx +: 8];
    assign win_onehot      = NUM_REQ'(1) << win_idx;
    assign tick            = (presc_cnt_q == presc_lat_q);
    assign ptr_after_owner = wrap_add(owner_q, 1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        done_d      = '0;
        busy_d      = busy_q;
        count_d     = count_q;
        presc_cnt_d = presc_cnt_q;
        presc_lat_d = presc_lat_q;
        ptr_d       = ptr_q;
        owner_d     = owner_q;

        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    owner_d     = win_idx;
                    grant_d     = win_onehot;
                    busy_d      = 1'b1;
                    count_d     = win_delay;
                    presc_lat_d = prescale;
                    presc_cnt_d = '0;
                    if (win_delay == 8'd0) begin
                        state_d = ST_DONE;
                        done_d  = win_onehot;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN: begin
                // Abort wins over a tick landing on the same edge.
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    busy_d  = 1'b0;
                    count_d = 8'd0;
                    ptr_d   = ptr_after_owner;
                end else if (tick) begin
                    presc_cnt_d = '0;
                    if (count_q <= 8'd1) begin
                        count_d = 8'd0;
                        state_d = ST_DONE;
                        done_d  = grant_q;
                    end else begin
                        count_d = count_q - 8'd1;
                    end
                end else begin
                    presc_cnt_d = presc_cnt_q + PRESCALE_W'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = 8'd0;
                ptr_d   = ptr_after_owner;
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                count_d = 8'd0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            grant_q     <= '0;
            done_q      <= '0;
            busy_q      <= 1'b0;
            count_q     <= 8'd0;
            presc_cnt_q <= '0;
            presc_lat_q <= '0;
            ptr_q       <= '0;
            owner_q     <= '0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            count_q     <= count_d;
            presc_cnt_q <= presc_cnt_d;
            presc_lat_q <= presc_lat_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
        end
    end

    assign grant     = grant_q;
    assign done      = done_q;
    assign busy      = busy_q;
    assign count_out = count_q;

endmodule

// File: tb/tb_timer_scheduler.sv
// Directed bench for timer_scheduler: a deadline-based model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_timer_scheduler;

    localparam int N = 4;

    logic           clock = 1'b0;
    logic           reset_n;
    logic [N-1:0]   req;
    logic [8*N-1:0] req_delay;
    logic [7:0]     prescale;
    logic [N-1:0]   grant;
    logic [N-1:0]   done;
    logic           busy;
    logic [7:0]     count_out;

    always #5 clock = ~clock;

    timer_scheduler #(.NUM_REQ(N), .PRESCALE_W(8)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .req_delay (req_delay),
        .prescale  (prescale),
        .grant     (grant),
        .done      (done),
        .busy      (busy),
        .count_out (count_out)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: owner, grant cycle, latched delay/prescale, cycle at which done is due.
    int m_owner = -1;
    int m_t0    = 0;
    int m_d     = 0;
    int m_p     = 0;
    int m_end   = 0;
    int m_ptr   = 0;

    logic [N-1:0] exp_rr [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_step();
        cyc++;
        if (!reset_n) begin
            m_owner = -1;
            m_ptr   = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (m_ptr + k) % N;
                if (m_owner < 0 && req[idx]) begin
                    m_owner = idx;
                    m_t0    = cyc;
                    m_d     = int'(req_delay[8*idx +: 8]);
                    m_p     = int'(prescale);
                    m_end   = cyc + m_d * (m_p + 1);
                end
            end
        end else if (cyc == m_end + 1) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end else if (!req[m_owner]) begin
            m_ptr   = (m_owner + 1) % N;
            m_owner = -1;
        end
    endtask

    task automatic model_compare();
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        int           ec;
        logic         eb;
        eg = '0;
        ed = '0;
        ec = 0;
        eb = 1'b0;
        if (m_owner >= 0) begin
            eg = N'(1) << m_owner;
            eb = 1'b1;
            ed = (cyc == m_end) ? eg : '0;
            ec = m_d - (cyc - m_t0) / (m_p + 1);
        end
        chk("model_grant", 32'(grant), 32'(eg));
        chk("model_done", 32'(done), 32'(ed));
        chk("model_busy", 32'(busy), 32'(eb));
        chk("model_count", 32'(count_out), 32'(ec));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        #1;
        model_compare();
        @(negedge clock);
    endtask

    initial begin
        reset_n   = 1'b0;
        req       = '0;
        req_delay = '0;
        prescale  = 8'd0;
        cycle();
        cycle();
        chk("reset_grant", 32'(grant), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_count", 32'(count_out), 32'd0);
        reset_n = 1'b1;

        // Round-robin: all pending, D=1, P=0.
        for (int i = 0; i < N; i++) req_delay[8*i +: 8] = 8'd1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("rr_grant", 32'(grant), 32'(exp_rr[k]));
            cycle();
            chk("rr_done", 32'(done), 32'(exp_rr[k]));
            if (k < 4) begin
                cycle();
                chk("rr_idle_gap", 32'(grant), 32'd0);
            end
        end
        req = '0;
        cycle();
        chk("rr_end_busy", 32'(busy), 32'd0);

        // Single request: D=3, P=0.
        req_delay[7:0] = 8'd3;
        prescale       = 8'd0;
        req            = 4'b0001;
        cycle();
        chk("single_grant", 32'(grant), 32'b0001);
        chk("single_cnt_t", 32'(count_out), 32'd3);
        cycle();
        chk("single_cnt_t1", 32'(count_out), 32'd2);
        cycle();
        chk("single_cnt_t2", 32'(count_out), 32'd1);
        chk("single_nodone_t2", 32'(done), 32'd0);
        cycle();
        chk("single_done_t3", 32'(done), 32'b0001);
        req = '0;
        cycle();
        chk("single_idle_t4", 32'(busy), 32'd0);
        chk("single_idle_done", 32'(done), 32'd0);

        // Prescale: D=2, P=2; later changes to delay/prescale must be ignored.
        req_delay[15:8] = 8'd2;
        prescale        = 8'd2;
        req             = 4'b0010;
        cycle();
        chk("presc_cnt_t", 32'(count_out), 32'd2);
        prescale        = 8'd0;
        req_delay[15:8] = 8'd7;
        cycle();
        cycle();
        chk("presc_cnt_t2", 32'(count_out), 32'd2);
        cycle();
        chk("presc_cnt_t3", 32'(count_out), 32'd1);
        cycle();
        cycle();
        chk("presc_nodone_t5", 32'(done), 32'd0);
        cycle();
        chk("presc_done_t6", 32'(done), 32'b0010);
        req = '0;
        cycle();
        chk("presc_idle", 32'(grant), 32'd0);

        // Zero delay on requester 2.
        req_delay[23:16] = 8'd0;
        req              = 4'b0100;
        cycle();
        chk("zero_grant", 32'(grant), 32'b0100);
        chk("zero_done", 32'(done), 32'b0100);
        chk("zero_busy", 32'(busy), 32'd1);
        req = '0;
        cycle();
        chk("zero_busy_off", 32'(busy), 32'd0);

        // Abort: requester 3 drops after 4 cycles, requester 0 pending.
        req_delay[31:24] = 8'd10;
        req_delay[7:0]   = 8'd2;
        prescale         = 8'd0;
        req              = 4'b1001;
        cycle();
        chk("abort_grant", 32'(grant), 32'b1000);
        cycle();
        cycle();
        cycle();
        req = 4'b0001;
        cycle();
        chk("abort_grant_off", 32'(grant), 32'd0);
        chk("abort_no_done", 32'(done), 32'd0);
        chk("abort_count", 32'(count_out), 32'd0);
        cycle();
        chk("abort_next_grant", 32'(grant), 32'b0001);
        cycle();
        cycle();
        chk("abort_next_done", 32'(done), 32'b0001);
        req = '0;
        cycle();

        // Reset mid-run with count_out=5.
        req_delay[23:16] = 8'd8;
        req_delay[15:8]  = 8'd1;
        req_delay[31:24] = 8'd1;
        req              = 4'b0100;
        cycle();
        chk("rst_run_grant", 32'(grant), 32'b0100);
        cycle();
        cycle();
        cycle();
        chk("rst_run_cnt5", 32'(count_out), 32'd5);
        reset_n = 1'b0;
        req     = 4'b1010;
        #1;
        chk("rst_async_grant", 32'(grant), 32'd0);
        chk("rst_async_busy", 32'(busy), 32'd0);
        chk("rst_async_done", 32'(done), 32'd0);
        chk("rst_async_count", 32'(count_out), 32'd0);
        cycle();
        reset_n = 1'b1;
        cycle();
        chk("rst_after_grant", 32'(grant), 32'b0010);
        cycle();
        chk("rst_after_done", 32'(done), 32'b0010);
        req = '0;
        cycle();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
